// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - RAW/load-use stall controller with in-flight destination scoreboard
module hazard_stall_ctrl #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_we,
  input  logic             flush,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [DEPTH-1:0] sb_v_q, sb_we_q;
  logic [4:0]       sb_rd_q [DEPTH];
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0] hit;
  logic             haz;
  logic [CNT_W-1:0] kmin, need;
  logic             stall;
  logic [CNT_W-1:0] cnt_out;
  logic             issue;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      hit[k] = sb_v_q[k] & sb_we_q[k] & (sb_rd_q[k] != 5'd0) &
               ((id_rs1_used & (id_rs1 == sb_rd_q[k])) |
                (id_rs2_used & (id_rs2 == sb_rd_q[k])));
    end
  end

  // Scan from the WB end down so the nearest producer wins.
  always_comb begin
    kmin = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit[k]) kmin = CNT_W'(k);
    end
  end

  assign haz  = id_valid & ~flush & (|hit);
  assign need = CNT_W'(DEPTH) - kmin;

  // stall_cnt reports cycles remaining after the current one; the register
  // holds the value to show in the following STALL cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    cnt_out = '0;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (state_q == ST_STALL) begin
      stall   = 1'b1;
      cnt_out = cnt_q;
      if (cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (haz) begin
      stall   = 1'b1;
      cnt_out = need - CNT_W'(1);
      if (need > CNT_W'(1)) begin
        state_d = ST_STALL;
        cnt_d   = need - CNT_W'(2);
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign issue = id_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      sb_v_q  <= '0;
      sb_we_q <= '0;
      for (int k = 0; k < DEPTH; k++) sb_rd_q[k] <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sb_v_q[0]  <= issue;
      sb_we_q[0] <= issue & id_rd_we;
      sb_rd_q[0] <= issue ? id_rd : 5'd0;
      for (int k = 1; k < DEPTH; k++) begin
        sb_v_q[k]  <= sb_v_q[k-1];
        sb_we_q[k] <= sb_we_q[k-1];
        sb_rd_q[k] <= sb_rd_q[k-1];
      end
    end
  end

  assign stall_pc    = stall;
  assign stall_ifid  = stall;
  assign bubble_idex = stall;
  assign stall_cnt   = cnt_out;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_pc, stall_ifid, bubble_idex;
  logic [1:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       stall;
    logic [1:0] cnt;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  hazard_stall_ctrl #(.DEPTH(3), .CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_rd_we    (id_rd_we),
    .flush       (flush),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .bubble_idex (bubble_idex),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic es, input logic [1:0] ec);
    chk({tag, ".stall_pc"},    {7'd0, stall_pc},    {7'd0, es});
    chk({tag, ".stall_ifid"},  {7'd0, stall_ifid},  {7'd0, es});
    chk({tag, ".bubble_idex"}, {7'd0, bubble_idex}, {7'd0, es});
    chk({tag, ".stall_cnt"},   {6'd0, stall_cnt},   {6'd0, ec});
  endtask

  // One pipeline cycle: drive ID after the edge, record the expectation, check mid-cycle.
  task automatic step(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic fl,
                      input logic es, input logic [1:0] ec, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; flush = fl;
    exp_q.push_back('{stall: es, cnt: ec, tag: tag});
    @(negedge clk);
    e = exp_q.pop_front();
    chk_outputs(e.tag, e.stall, e.cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, "idle");
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs2 = 5'd0; id_rs2_used = 1'b0;
    id_rd = 5'd5; id_rd_we = 1'b1; flush = 1'b0;
    #12;
    chk_outputs("reset", 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x5,x0,1 then add x6,x5,x1: three stall cycles, count 2,1,0
    step(1, 0, 1, 0, 0, 5, 1, 0, 0, 2'd0, "t1_addi");
    step(1, 5, 1, 1, 1, 6, 1, 0, 1, 2'd2, "t1_s0");
    step(1, 5, 1, 1, 1, 6, 1, 0, 1, 2'd1, "t1_s1");
    step(1, 5, 1, 1, 1, 6, 1, 0, 1, 2'd0, "t1_s2");
    step(1, 5, 1, 1, 1, 6, 1, 0, 0, 2'd0, "t1_go");
    idle(3);

    // x0 destination is never live
    step(1, 0, 1, 0, 0, 0, 1, 0, 0, 2'd0, "t2_addi_x0");
    step(1, 0, 1, 0, 1, 7, 1, 0, 0, 2'd0, "t2_add");
    idle(3);

    // rs2 field matches but is unused
    step(1, 0, 1, 0, 0, 5, 1, 0, 0, 2'd0, "t3_addi");
    step(1, 1, 1, 5, 0, 8, 1, 0, 0, 2'd0, "t3_imm");
    idle(3);

    // lw x3, unrelated, sw x3: producer in MEM, two stall cycles
    step(1, 2, 1, 0, 0, 3, 1, 0, 0, 2'd0, "t4_lw");
    step(1, 11, 1, 12, 1, 10, 1, 0, 0, 2'd0, "t4_other");
    step(1, 4, 1, 3, 1, 0, 0, 0, 1, 2'd1, "t4_s0");
    step(1, 4, 1, 3, 1, 0, 0, 0, 1, 2'd0, "t4_s1");
    step(1, 4, 1, 3, 1, 0, 0, 0, 0, 2'd0, "t4_go");
    idle(3);

    // rs1 hits MEM, rs2 hits EX: nearest producer sets the length
    step(1, 0, 1, 0, 0, 5, 1, 0, 0, 2'd0, "tb_x5");
    step(1, 0, 1, 0, 0, 6, 1, 0, 0, 2'd0, "tb_x6");
    step(1, 5, 1, 6, 1, 7, 1, 0, 1, 2'd2, "tb_s0");
    step(1, 5, 1, 6, 1, 7, 1, 0, 1, 2'd1, "tb_s1");
    step(1, 5, 1, 6, 1, 7, 1, 0, 1, 2'd0, "tb_s2");
    step(1, 5, 1, 6, 1, 7, 1, 0, 0, 2'd0, "tb_go");
    idle(3);

    // flush in the second stall cycle; x5 keeps draining, flushed x9 never enters
    step(1, 0, 1, 0, 0, 5, 1, 0, 0, 2'd0, "t5_addi");
    step(1, 5, 1, 0, 0, 6, 1, 0, 1, 2'd2, "t5_s0");
    step(1, 5, 1, 0, 0, 9, 1, 1, 0, 2'd0, "t5_flush");
    step(1, 9, 1, 5, 1, 0, 0, 0, 1, 2'd0, "t5_wb_hit");
    step(1, 9, 1, 5, 1, 0, 0, 0, 0, 2'd0, "t5_clear");
    idle(3);

    // asynchronous reset in the middle of a stall
    step(1, 0, 1, 0, 0, 5, 1, 0, 0, 2'd0, "t6_addi");
    step(1, 5, 1, 0, 0, 6, 1, 0, 1, 2'd2, "t6_s0");
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs("t6_async_rst", 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 5, 1, 0, 0, 6, 1, 0, 0, 2'd0, "t6_after");

    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
